// File: rtl/mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_pkg : shared types and constants for the MEM stage controller     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package mem_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_W_DEF  = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mem_state_t;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
    } memwb_ctrl_t;

    localparam memwb_ctrl_t MEMWB_BUBBLE = '{reg_write: 1'b0, mem_to_reg: 1'b0};

endpackage
`default_nettype wire

// File: rtl/memwb_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | memwb_reg : MEM/WB pipeline register with load and bubble controls    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module memwb_reg
    import mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_W  = REG_W_DEF
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              load,
    input  logic              bubble,
    input  logic              reg_write_in,
    input  logic              mem_to_reg_in,
    input  logic [DATA_W-1:0] result_in,
    input  logic [DATA_W-1:0] read_data_in,
    input  logic [REG_W-1:0]  reg_dest_in,
    output logic              reg_write,
    output logic              mem_to_reg,
    output logic [DATA_W-1:0] result,
    output logic [DATA_W-1:0] read_data,
    output logic [REG_W-1:0]  reg_dest
);

    // A bubble only clears the control fields; data fields keep their value.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            reg_write  <= 1'b0;
            mem_to_reg <= 1'b0;
            result     <= '0;
            read_data  <= '0;
            reg_dest   <= '0;
        end else if (bubble) begin
            reg_write  <= MEMWB_BUBBLE.reg_write;
            mem_to_reg <= MEMWB_BUBBLE.mem_to_reg;
        end else if (load) begin
            reg_write  <= reg_write_in;
            mem_to_reg <= mem_to_reg_in;
            result     <= result_in;
            read_data  <= read_data_in;
            reg_dest   <= reg_dest_in;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_stage_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_stage_ctrl : MIPS MEM stage, data-memory handshake and stall      |
// | Optional macro MEM_ALIGN_CHECK_EN adds misalignment detection.        |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module mem_stage_ctrl
    import mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_W  = REG_W_DEF
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              iMemRead,
    input  logic              iMemWrite,
    input  logic              iMemToReg,
    input  logic              iRegWrite,
    input  logic              iBranchs,
    input  logic              iZero,
    input  logic [DATA_W-1:0] iResult,
    input  logic [DATA_W-1:0] iB,
    input  logic [REG_W-1:0]  iRegDest,
    input  logic [DATA_W-1:0] iBranch,
    output logic              oStall,
    output logic              oPCSrc,
    output logic [DATA_W-1:0] oBranchTarget,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ready,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              oRegWrite,
    output logic              oMemToReg,
    output logic [DATA_W-1:0] oResult,
    output logic [DATA_W-1:0] oReadData,
    output logic [REG_W-1:0]  oRegDest
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic              oAlignErr
`endif
);

    mem_state_t        state;
    logic [DATA_W-3:0] addr_word;
    logic [DATA_W-1:0] rdata_q;
    logic              mem_op;
    logic              misaligned;
    logic              start;
    logic              align_bubble;
    logic              memwb_load;

    assign mem_op = iMemRead | iMemWrite;

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = mem_op && (iResult[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign start         = (state == ST_IDLE) && mem_op && !misaligned;
    assign align_bubble  = (state == ST_IDLE) && misaligned;
    assign oStall        = start || (state == ST_BUSY);
    assign memwb_load    = ((state == ST_IDLE) && !mem_op) || (state == ST_DONE);
    assign oPCSrc        = iBranchs & iZero;
    assign oBranchTarget = iBranch;
    // Only word-aligned addresses ever reach the memory.
    assign dmem_addr     = {addr_word, 2'b00};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            addr_word  <= '0;
            dmem_wdata <= '0;
            rdata_q    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        addr_word  <= iResult[DATA_W-1:2];
                        dmem_wdata <= iB;
                        dmem_we    <= iMemWrite & ~iMemRead;
                        dmem_req   <= 1'b1;
                        state      <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (dmem_ready) begin
                        rdata_q  <= dmem_rdata;
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    dmem_req <= 1'b0;
                    dmem_we  <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            oAlignErr <= 1'b0;
        end else begin
            oAlignErr <= align_bubble;
        end
    end
`endif

    memwb_reg #(
        .DATA_W (DATA_W),
        .REG_W  (REG_W)
    ) u_memwb (
        .clock         (clock),
        .reset_n       (reset_n),
        .load          (memwb_load),
        .bubble        (oStall | align_bubble),
        .reg_write_in  (iRegWrite),
        .mem_to_reg_in (iMemToReg),
        .result_in     (iResult),
        .read_data_in  (rdata_q),
        .reg_dest_in   (iRegDest),
        .reg_write     (oRegWrite),
        .mem_to_reg    (oMemToReg),
        .result        (oResult),
        .read_data     (oReadData),
        .reg_dest      (oRegDest)
    );

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mem_stage_ctrl : scoreboard bench for mem_stage_ctrl               |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_mem_stage_ctrl;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        iMemRead, iMemWrite, iMemToReg, iRegWrite, iBranchs, iZero;
    logic [31:0] iResult, iB, iBranch;
    logic [4:0]  iRegDest;
    logic        oStall, oPCSrc;
    logic [31:0] oBranchTarget;
    logic        dmem_req, dmem_we, dmem_ready;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        oRegWrite, oMemToReg;
    logic [31:0] oResult, oReadData;
    logic [4:0]  oRegDest;
`ifdef MEM_ALIGN_CHECK_EN
    logic        oAlignErr;
`endif

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic        rw;
        logic        m2r;
        logic [31:0] res;
        logic [31:0] rdata;
        logic [4:0]  dest;
        logic        is_load;
    } exp_t;

    exp_t sb[$];

    always #5 clock = ~clock;

    mem_stage_ctrl #(.DATA_W(32), .REG_W(5)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .iMemRead      (iMemRead),
        .iMemWrite     (iMemWrite),
        .iMemToReg     (iMemToReg),
        .iRegWrite     (iRegWrite),
        .iBranchs      (iBranchs),
        .iZero         (iZero),
        .iResult       (iResult),
        .iB            (iB),
        .iRegDest      (iRegDest),
        .iBranch       (iBranch),
        .oStall        (oStall),
        .oPCSrc        (oPCSrc),
        .oBranchTarget (oBranchTarget),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .dmem_ready    (dmem_ready),
        .dmem_rdata    (dmem_rdata),
        .oRegWrite     (oRegWrite),
        .oMemToReg     (oMemToReg),
        .oResult       (oResult),
        .oReadData     (oReadData),
        .oRegDest      (oRegDest)
`ifdef MEM_ALIGN_CHECK_EN
        ,
        .oAlignErr     (oAlignErr)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drives one EX/MEM instruction, plays the memory, and checks MEM/WB on completion.
    task automatic run_op(input string tag, input logic mr, input logic mw, input logic m2r,
                          input logic rw, input logic [31:0] res, input logic [31:0] bval,
                          input logic [4:0] dest, input logic [31:0] rdata,
                          input int waits, input int exp_stall);
        exp_t        e;
        exp_t        got_e;
        int          stall_cnt;
        int          busy;
        bit          done;
        bit          prev_stall;
        logic [31:0] exp_addr;
        e.rw = rw; e.m2r = m2r; e.res = res; e.rdata = rdata; e.dest = dest; e.is_load = mr;
        sb.push_back(e);
        exp_addr   = {res[31:2], 2'b00};
        iMemRead   = mr;  iMemWrite = mw; iMemToReg = m2r; iRegWrite = rw;
        iResult    = res; iB = bval;      iRegDest = dest;
        dmem_rdata = rdata;
        dmem_ready = (waits == 0);
        stall_cnt  = 0; busy = 0; done = 0; prev_stall = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            #1;
            if (prev_stall) begin
                check_eq({tag, " bubble_rw"}, {31'd0, oRegWrite}, 32'd0);
                check_eq({tag, " bubble_m2r"}, {31'd0, oMemToReg}, 32'd0);
            end
            if (!(mr | mw)) begin
                check_eq({tag, " no_req"}, {31'd0, dmem_req}, 32'd0);
            end else if (dmem_req) begin
                busy++;
                check_eq({tag, " addr"}, dmem_addr, exp_addr);
                check_eq({tag, " we"}, {31'd0, dmem_we}, {31'd0, mw & ~mr});
                if (mw & ~mr) check_eq({tag, " wdata"}, dmem_wdata, bval);
                if (waits != 0) dmem_ready = (busy > waits);
            end
            prev_stall = oStall;
            if (oStall) stall_cnt++;
            else done = 1;
            @(negedge clock);
        end
        dmem_ready = 1'b0;
        check_eq({tag, " completed"}, {31'd0, done}, 32'd1);
        check_eq({tag, " stall_cycles"}, stall_cnt, exp_stall);
        if (sb.size() > 0) begin
            got_e = sb.pop_front();
            check_eq({tag, " oRegWrite"}, {31'd0, oRegWrite}, {31'd0, got_e.rw});
            check_eq({tag, " oMemToReg"}, {31'd0, oMemToReg}, {31'd0, got_e.m2r});
            check_eq({tag, " oResult"}, oResult, got_e.res);
            check_eq({tag, " oRegDest"}, {27'd0, oRegDest}, {27'd0, got_e.dest});
            if (got_e.is_load) check_eq({tag, " oReadData"}, oReadData, got_e.rdata);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        iMemRead = 0; iMemWrite = 0; iMemToReg = 0; iRegWrite = 0; iBranchs = 0; iZero = 0;
        iResult = '0; iB = '0; iBranch = '0; iRegDest = '0;
        dmem_ready = 0; dmem_rdata = '0;
        repeat (2) @(negedge clock);
        check_eq("rst dmem_req", {31'd0, dmem_req}, 32'd0);
        check_eq("rst dmem_we", {31'd0, dmem_we}, 32'd0);
        check_eq("rst dmem_addr", dmem_addr, 32'd0);
        check_eq("rst dmem_wdata", dmem_wdata, 32'd0);
        check_eq("rst oStall", {31'd0, oStall}, 32'd0);
        check_eq("rst oRegWrite", {31'd0, oRegWrite}, 32'd0);
        check_eq("rst oMemToReg", {31'd0, oMemToReg}, 32'd0);
        check_eq("rst oResult", oResult, 32'd0);
        check_eq("rst oReadData", oReadData, 32'd0);
        check_eq("rst oRegDest", {27'd0, oRegDest}, 32'd0);
        reset_n = 1'b1;

        // Branch resolution is combinational and independent of the FSM.
        iBranchs = 1; iZero = 1; iBranch = 32'h80;
        #1;
        check_eq("br taken pcsrc", {31'd0, oPCSrc}, 32'd1);
        check_eq("br target", oBranchTarget, 32'h80);
        iZero = 0;
        #1;
        check_eq("br not_taken pcsrc", {31'd0, oPCSrc}, 32'd0);
        iBranchs = 0;
        @(negedge clock);

        run_op("alu", 0, 0, 0, 1, 32'h40, 32'h0, 5'd5, 32'h0, 0, 0);
        run_op("load0", 1, 0, 1, 1, 32'h100, 32'h0, 5'd7, 32'hDEADBEEF, 0, 2);
        run_op("store3", 0, 1, 0, 0, 32'h200, 32'h1234, 5'd0, 32'h0, 3, 5);
        run_op("ld_b2b_a", 1, 0, 1, 1, 32'h300, 32'h0, 5'd8, 32'hA5A5_0001, 0, 2);
        run_op("ld_b2b_b", 1, 0, 1, 1, 32'h304, 32'h0, 5'd9, 32'h5A5A_0002, 1, 3);
        run_op("rd_wr_both", 1, 1, 1, 1, 32'h40C, 32'hFFFF, 5'd10, 32'hC0FFEE00, 2, 4);
`ifndef MEM_ALIGN_CHECK_EN
        run_op("ld_unaligned", 1, 0, 1, 1, 32'h103, 32'h0, 5'd11, 32'h1111_2222, 0, 2);
`endif
        run_op("alu2", 0, 0, 0, 1, 32'h1234_5678, 32'h0, 5'd31, 32'h0, 0, 0);

`ifdef MEM_ALIGN_CHECK_EN
        iMemRead = 1; iMemWrite = 0; iMemToReg = 1; iRegWrite = 1;
        iResult = 32'h102; iRegDest = 5'd12;
        #1;
        check_eq("align oStall", {31'd0, oStall}, 32'd0);
        check_eq("align no_req", {31'd0, dmem_req}, 32'd0);
        @(negedge clock);
        check_eq("align err_pulse", {31'd0, oAlignErr}, 32'd1);
        check_eq("align oRegWrite", {31'd0, oRegWrite}, 32'd0);
        check_eq("align no_req2", {31'd0, dmem_req}, 32'd0);
        iMemRead = 0; iMemToReg = 0; iRegWrite = 0; iResult = 32'h0;
        @(negedge clock);
        check_eq("align err_clear", {31'd0, oAlignErr}, 32'd0);
`endif

        // Asynchronous reset in the middle of a long access.
        iMemRead = 1; iMemWrite = 0; iMemToReg = 1; iRegWrite = 1;
        iResult = 32'h500; iRegDest = 5'd3; dmem_rdata = 32'hBAD0BAD0; dmem_ready = 0;
        @(negedge clock);
        #1;
        check_eq("rstmid req_before", {31'd0, dmem_req}, 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        check_eq("rstmid req_drop", {31'd0, dmem_req}, 32'd0);
        check_eq("rstmid oResult", oResult, 32'd0);
        check_eq("rstmid oRegDest", {27'd0, oRegDest}, 32'd0);
        iMemRead = 0; iMemToReg = 0; iRegWrite = 0; iResult = 32'h0; iRegDest = 5'd0;
        #1;
        check_eq("rstmid oStall", {31'd0, oStall}, 32'd0);
        dmem_ready = 1;
        @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        check_eq("rstmid late_ready_req", {31'd0, dmem_req}, 32'd0);
        check_eq("rstmid late_ready_rdata", oReadData, 32'd0);
        check_eq("rstmid oStall_after", {31'd0, oStall}, 32'd0);
        dmem_ready = 0;
        run_op("alu_after_rst", 0, 0, 0, 1, 32'h77, 32'h0, 5'd4, 32'h0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
